// File: rtl/ls_store_buffer_unit.sv
// Load/store unit with a speculative store buffer. Stores reach memory only after commit.
// Loads forward from the youngest matching buffered store, otherwise they read memory.
module ls_store_buffer_unit #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int SB_DEPTH  = 8,
    parameter int ROB_IDX_W = 4,
    parameter int MEM_BYTES = 16384
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic                        in_start,
    input  logic                        in_is_store,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_wval,
    input  logic [ROB_IDX_W-1:0]        in_dst_rob_index,
    input  logic                        in_commit_store,
    input  logic                        in_squash,
    output logic                        out_ready,
    output logic                        out_done,
    output logic [ROB_IDX_W-1:0]        out_dst_rob_index,
    output logic [DATA_W-1:0]           out_value,
    output logic [$clog2(SB_DEPTH):0]   out_sb_count
);
    localparam int PTR_W     = $clog2(SB_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int OFF_W     = $clog2(DATA_W / 8);
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam int IDX_W     = MEM_AW - OFF_W;
    localparam int MEM_WORDS = MEM_BYTES / (DATA_W / 8);

    logic [PTR_W-1:0]     head_q, head_d, commit_q, commit_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d, spec_q, spec_d;
    logic [SB_DEPTH-1:0]  cmt_q, cmt_d;
    logic                 done_q, done_d;
    logic [ROB_IDX_W-1:0] rob_q, rob_d;
    logic [DATA_W-1:0]    val_q, val_d;

    logic [IDX_W-1:0]     sb_idx_q  [SB_DEPTH];
    logic [DATA_W-1:0]    sb_data_q [SB_DEPTH];
    logic [DATA_W-1:0]    mem_q     [MEM_WORDS];

    logic                 accept, st_acc, ld_acc, commit_ok, drain;
    logic [IDX_W-1:0]     op_idx;
    logic [DATA_W-1:0]    ld_val;
    logic [PTR_W-1:0]     slot;

    logic unused_ok;
    assign unused_ok = ^in_addr;

    assign out_ready         = (count_q < CNT_W'(SB_DEPTH));
    assign out_done          = done_q;
    assign out_dst_rob_index = rob_q;
    assign out_value         = val_q;
    assign out_sb_count      = count_q;

    assign accept    = in_start & out_ready & ~in_squash;
    assign st_acc    = accept & in_is_store;
    assign ld_acc    = accept & ~in_is_store;
    assign commit_ok = in_commit_store & (spec_q != '0);
    assign drain     = (count_q != '0) & cmt_q[head_q];
    assign op_idx    = in_addr[MEM_AW-1:OFF_W];

    // Walk oldest to youngest so the youngest matching entry overrides.
    always_comb begin
        ld_val = mem_q[op_idx];
        slot   = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (sb_idx_q[slot] == op_idx))
                ld_val = sb_data_q[slot];
        end
    end

    always_comb begin
        head_d   = head_q + PTR_W'(drain);
        commit_d = commit_q + PTR_W'(commit_ok);
        tail_d   = tail_q + PTR_W'(st_acc);
        count_d  = count_q + CNT_W'(st_acc) - CNT_W'(drain);
        spec_d   = spec_q + CNT_W'(st_acc) - CNT_W'(commit_ok);
        cmt_d    = cmt_q;
        if (drain)     cmt_d[head_q]   = 1'b0;
        if (commit_ok) cmt_d[commit_q] = 1'b1;
        if (st_acc)    cmt_d[tail_q]   = 1'b0;
        // Squash keeps only the committed region, including a same-edge commit.
        if (in_squash) begin
            tail_d  = commit_d;
            spec_d  = '0;
            count_d = count_q - spec_q + CNT_W'(commit_ok) - CNT_W'(drain);
        end
        done_d = accept;
        rob_d  = accept ? in_dst_rob_index : '0;
        val_d  = ld_acc ? ld_val : '0;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            spec_q   <= '0;
            cmt_q    <= '0;
            done_q   <= 1'b0;
            rob_q    <= '0;
            val_q    <= '0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            spec_q   <= spec_d;
            cmt_q    <= cmt_d;
            done_q   <= done_d;
            rob_q    <= rob_d;
            val_q    <= val_d;
        end
    end

    // Payload and memory carry no reset; validity comes from the pointers.
    always_ff @(posedge in_clk) begin
        if (drain) mem_q[sb_idx_q[head_q]] <= sb_data_q[head_q];
        if (st_acc) begin
            sb_idx_q[tail_q]  <= op_idx;
            sb_data_q[tail_q] <= in_wval;
        end
    end

    assert property (@(posedge in_clk) disable iff (!in_rst)
        !(in_commit_store && (spec_q == '0)))
        else $error("commit with no speculative store");

endmodule

// File: doc/ls_store_buffer_unit.md
Name: ls_store_buffer_unit

Overview:
- Parametrised load/store functional unit. It is the next generation of the execute-stage LS path.
- Stores are held in a speculative store buffer and written to data memory only after the ROB commits them. Mispredicted stores are therefore discarded without touching memory.
- Loads read the youngest matching buffered store (forwarding) or fall back to memory. Results return to the ROB on the shared FU result channel.
- Sits between the LS reservation station and the ROB, alongside the ALU.

Parameters:
- DATA_W, 64, data/word width in bits; must be a multiple of 8.
- ADDR_W, 64, address width of in_addr.
- SB_DEPTH, 8, store buffer entries; power of 2, minimum 2.
- ROB_IDX_W, 4, ROB index width.
- MEM_BYTES, 16384, internal data memory size in bytes; power of 2.

Ports:
- in_clk  input  1  clock; all state updates on posedge.
- in_rst  input  1  asynchronous, active-low reset.
- in_start  input  1  RS issues an op this cycle.
- in_is_store  input  1  1 = STUR, 0 = LDUR.
- in_addr  input  ADDR_W  byte address. Low log2(DATA_W/8) bits are ignored (aligned access). Index bits are addr[log2(MEM_BYTES)-1:log2(DATA_W/8)].
- in_wval  input  DATA_W  store data.
- in_dst_rob_index  input  ROB_IDX_W  ROB slot of the op.
- in_commit_store  input  1  ROB committed the oldest uncommitted store.
- in_squash  input  1  mispredict flush.
- out_ready  output  1  op can be accepted this cycle.
- out_done  output  1  result valid (1-cycle pulse).
- out_dst_rob_index  output  ROB_IDX_W  ROB slot of the result.
- out_value  output  DATA_W  load data; 0 for stores.
- out_sb_count  output  log2(SB_DEPTH)+1  occupied buffer entries.

Behaviour:
- Reset (in_rst=0, async): head, commit and tail pointers = 0; count = 0; all entries invalid; out_done=0, out_dst_rob_index=0, out_value=0; out_ready=1. Memory contents are untouched. Entries pending drain at reset are lost by definition.
- Buffer is a circular FIFO. Each entry holds {addr index, data, committed}. Pointers wrap modulo SB_DEPTH. Region order: head..commit-1 is committed; commit..tail-1 is speculative.
- out_ready = (count < SB_DEPTH). It is combinational from registered count and gates loads as well as stores.
- Accept = in_start & out_ready & ~in_squash. An op presented while out_ready=0 is ignored; the RS must hold it.
- Store accept at edge T:
  - write entry at tail; tail+1.
  - at T+1: out_done=1, out_value=0, out_dst_rob_index = the op's index.
- Load accept at edge T:
  - Value is resolved combinationally in the accept cycle, before edge T. Search all valid entries (committed and speculative) for an address-index match; the youngest match wins. With no match, read memory.
  - Value is registered at edge T and presented at T+1 with out_done=1.
  - Latency is exactly 1 cycle.
- out_done is a pulse: 0 in any cycle following an edge with no accept.
- Commit: an in_commit_store sampled at edge marks the entry at commit pointer committed; commit+1.
  - Commit while no speculative entry exists is an error: raise `ASSERT and ignore.
- Drain: each edge where the head entry is committed, write its data to memory and advance head. At most 1 drain per cycle.
  - An entry committed at edge T drains no earlier than edge T+1.
- Squash sampled at edge:
  - tail := commit pointer, after applying a same-edge commit. Speculative entries vanish.
  - out_done := 0 at the next cycle.
  - A same-cycle in_start is dropped.
  - Committed entries still drain normally.
- Simultaneous accept, commit and drain in one edge are all legal.
  - Count update is +accept-store minus drain.
  - A load accepted in the same cycle as a drain forwards from the entry being drained; the data is identical, so there is no hazard.
- Store and drain to the same address in one cycle: memory gets drain data, the buffer keeps the new entry.
- Full buffer with a committed head: the drain frees a slot, so out_ready=1 in the next cycle.

Test Plan:
- Reset mid-run with 3 entries (2 committed) -> out_sb_count=0, out_done=0, out_ready=1 immediately and asynchronously. Memory at those addresses keeps its old value.
- STUR addr 0x40 val 0x1122334455667788, rob 3; LDUR 0x40 rob 4 next cycle (no commit) -> done for rob 3 with value 0. Then done for rob 4 with value 0x1122334455667788, forwarded. Memory[0x40] unchanged.
- Two stores to 0x80 (val 5, then val 9), then LDUR 0x80 -> 9 (youngest match). Commit both -> memory reads 5 then 9 over 2 drain cycles. LDUR 0x80 after count=0 -> 9 from memory.
- Store 0x100=7, commit; store 0x108=8 (speculative); assert squash -> out_sb_count 2→1→0 as the committed entry drains. Memory[0x100]=7, memory[0x108] unchanged. A later load of 0x108 returns the original memory value.
- Fill SB_DEPTH=8 speculative stores -> out_ready=0 and a 9th start is ignored (no out_done). One commit -> the drain frees a slot, out_ready=1 two cycles after the commit edge. Pointers wrap to 0 correctly over 20 store/commit pairs.
- Squash asserted in the same cycle as in_start of a load -> no out_done next cycle. A commit on the same edge is retained and drains.
